// File: rtl/fp32_div_pkg.sv
// Shared types and constants for the FP32 divide front end.
// Denormal support in div_pre_processing is selected by DIV_PRE_DENORM_EN.
package fp32_div_pkg;

  localparam int FP32_BIAS = 127;
  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int QEXP_W    = 10;
  localparam int SIG_W     = FRAC_W + 1;
  localparam int LZ_W      = 5;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    NAN    = 2'd1,
    INF    = 2'd2,
    ZERO   = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [SIG_W-1:0]  sig_a;
    logic [SIG_W-1:0]  sig_b;
    logic [LZ_W-1:0]   lz_a;
    logic [LZ_W-1:0]   lz_b;
    fp_class_e         cls;
  } s1_data_t;

  // Earlier tests win: invalid operations first, then the infinite and zero quotients.
  function automatic fp_class_e classify(input logic nan_a, input logic inf_a,
                                         input logic zero_a, input logic nan_b,
                                         input logic inf_b, input logic zero_b);
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) return NAN;
    else if (inf_a || zero_b) return INF;
    else if (zero_a || inf_b) return ZERO;
    else return NORMAL;
  endfunction

endpackage

// File: rtl/lzc24.sv
// Combinational 24-bit leading-zero counter; an all-zero input yields 24.
module lzc24
  import fp32_div_pkg::*;
(
  input  logic [SIG_W-1:0] in_bits,
  output logic [LZ_W-1:0]  count
);

  // Scanning upward lets the highest set bit have the last word.
  always_comb begin
    count = LZ_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++) begin
      if (in_bits[i]) count = LZ_W'(SIG_W - 1 - i);
    end
  end

endmodule

// File: rtl/div_pre_processing.sv
// Two-stage FP32 divide operand unpacker: classify, normalize, form quotient exponent.
// Define DIV_PRE_DENORM_EN to normalize denormals; otherwise they are flushed to zero.
module div_pre_processing
  import fp32_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       dividend,
  input  logic [31:0]       divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIG_W-1:0]  mant_a,
  output logic [SIG_W-1:0]  mant_b,
  output logic              resultsign,
  output logic [QEXP_W-1:0] current_exponent,
  output logic [1:0]        special
);

  // Handshake: a transfer happens on a cycle where valid && ready are both high at the
  // rising edge; a producer holds valid and data steady until that transfer, and ready
  // may depend combinationally on the consumer's ready (never on the producer's valid).
  logic              v1_d, v1_q;
  logic              v2_d, v2_q;
  s1_data_t          s1_d, s1_q;
  logic [SIG_W-1:0]  mant_a_d, mant_a_q;
  logic [SIG_W-1:0]  mant_b_d, mant_b_q;
  logic              resultsign_d, resultsign_q;
  logic [QEXP_W-1:0] cur_exp_d, cur_exp_q;
  fp_class_e         special_d, special_q;

  logic load2;
  logic accept;

  assign load2    = !v2_q || out_ready;
  assign in_ready = rst_n && (!v1_q || load2);
  assign accept   = in_valid && in_ready;

  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic [SIG_W-1:0]  sig_a, sig_b;
  logic [LZ_W-1:0]   lz_a, lz_b;
  logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

  always_comb begin
    exp_a  = dividend[30:23];
    exp_b  = divisor[30:23];
    frac_a = dividend[22:0];
    frac_b = divisor[22:0];
    inf_a  = (exp_a == '1) && (frac_a == '0);
    inf_b  = (exp_b == '1) && (frac_b == '0);
    nan_a  = (exp_a == '1) && (frac_a != '0);
    nan_b  = (exp_b == '1) && (frac_b != '0);
`ifdef DIV_PRE_DENORM_EN
    zero_a = (exp_a == '0) && (frac_a == '0);
    zero_b = (exp_b == '0) && (frac_b == '0);
    sig_a  = {exp_a != '0, frac_a};
    sig_b  = {exp_b != '0, frac_b};
`else
    // Flush-to-zero: any zero exponent field is a zero operand.
    zero_a = (exp_a == '0);
    zero_b = (exp_b == '0);
    sig_a  = {1'b1, frac_a};
    sig_b  = {1'b1, frac_b};
`endif
  end

`ifdef DIV_PRE_DENORM_EN
  lzc24 u_lzc_a (.in_bits(sig_a), .count(lz_a));
  lzc24 u_lzc_b (.in_bits(sig_b), .count(lz_b));
`else
  assign lz_a = '0;
  assign lz_b = '0;
`endif

  // Stage 1: capture on transfer, empty when the held pair advances.
  always_comb begin
    v1_d = v1_q;
    s1_d = s1_q;
    if (accept) begin
      v1_d       = 1'b1;
      s1_d.sign  = dividend[31] ^ divisor[31];
      s1_d.exp_a = (exp_a == '0) ? EXP_W'(1) : exp_a;
      s1_d.exp_b = (exp_b == '0) ? EXP_W'(1) : exp_b;
      s1_d.sig_a = sig_a;
      s1_d.sig_b = sig_b;
      s1_d.lz_a  = lz_a;
      s1_d.lz_b  = lz_b;
      s1_d.cls   = classify(nan_a, inf_a, zero_a, nan_b, inf_b, zero_b);
    end else if (load2) begin
      v1_d = 1'b0;
    end
  end

  logic [QEXP_W-1:0] ea_w, eb_w, lza_w, lzb_w;

  always_comb begin
    ea_w  = {{(QEXP_W-EXP_W){1'b0}}, s1_q.exp_a};
    eb_w  = {{(QEXP_W-EXP_W){1'b0}}, s1_q.exp_b};
    lza_w = {{(QEXP_W-LZ_W){1'b0}}, s1_q.lz_a};
    lzb_w = {{(QEXP_W-LZ_W){1'b0}}, s1_q.lz_b};
  end

  // Stage 2: output registers only move when the downstream side can take a new value.
  always_comb begin
    v2_d         = v2_q;
    mant_a_d     = mant_a_q;
    mant_b_d     = mant_b_q;
    resultsign_d = resultsign_q;
    cur_exp_d    = cur_exp_q;
    special_d    = special_q;
    if (load2) begin
      v2_d = v1_q;
      if (v1_q) begin
        resultsign_d = s1_q.sign;
        special_d    = s1_q.cls;
        if (s1_q.cls == NORMAL) begin
          mant_a_d  = s1_q.sig_a << s1_q.lz_a;
          mant_b_d  = s1_q.sig_b << s1_q.lz_b;
          // Wraps in 10-bit two's complement; the reachable range fits without saturation.
          cur_exp_d = (ea_w - lza_w) - (eb_w - lzb_w) + QEXP_W'(FP32_BIAS);
        end else begin
          mant_a_d  = '0;
          mant_b_d  = '0;
          cur_exp_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      s1_q         <= '0;
      mant_a_q     <= '0;
      mant_b_q     <= '0;
      resultsign_q <= 1'b0;
      cur_exp_q    <= '0;
      special_q    <= NORMAL;
    end else begin
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      s1_q         <= s1_d;
      mant_a_q     <= mant_a_d;
      mant_b_q     <= mant_b_d;
      resultsign_q <= resultsign_d;
      cur_exp_q    <= cur_exp_d;
      special_q    <= special_d;
    end
  end

  assign out_valid        = v2_q;
  assign mant_a           = mant_a_q;
  assign mant_b           = mant_b_q;
  assign resultsign       = resultsign_q;
  assign current_exponent = cur_exp_q;
  assign special          = special_q;

endmodule

// File: tb/tb_div_pre_processing.sv
// Directed bench for div_pre_processing: vector table, streaming, stall and reset cases.
// Expectations follow DIV_PRE_DENORM_EN when it is defined for the build.
module tb_div_pre_processing;
  import fp32_div_pkg::*;

  localparam int RW = 61;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [23:0] ma;
    logic [23:0] mb;
    logic        s;
    logic [9:0]  e;
    logic [1:0]  sp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic        resultsign;
  logic [9:0]  current_exponent;
  logic [1:0]  special;

  div_pre_processing dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .dividend         (dividend),
    .divisor          (divisor),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .mant_a           (mant_a),
    .mant_b           (mant_b),
    .resultsign       (resultsign),
    .current_exponent (current_exponent),
    .special          (special)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [RW-1:0] exp_q[$];
  int acc_q[$];
  int out_cyc_q[$];
  logic lat_chk = 1'b0;
  vec_t vecs[$];

  logic [RW-1:0] out_pk;
  assign out_pk = {mant_a, mant_b, resultsign, current_exponent, special};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [RW-1:0] pk(input vec_t v);
    return {v.ma, v.mb, v.s, v.e, v.sp};
  endfunction

  task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [23:0] ma,
                     input logic [23:0] mb, input logic s, input logic [9:0] e,
                     input logic [1:0] sp);
    vec_t v;
    v.a = a; v.b = b; v.ma = ma; v.mb = mb; v.s = s; v.e = e; v.sp = sp;
    vecs.push_back(v);
  endtask

  // Scoreboard: every retired result is compared with the oldest expectation.
  always @(negedge clk) begin
    int a;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(out_pk), 64'(0));
      end else begin
        check("result", 64'(out_pk), 64'(exp_q.pop_front()));
        a = acc_q.pop_front();
        if (lat_chk) check("latency", 64'(cyc - a), 64'(2));
        out_cyc_q.push_back(cyc);
      end
    end
  end

  // Driver tasks: entered and left just after a rising edge.
  task automatic send(input vec_t v);
    int n = 0;
    in_valid = 1'b1;
    dividend = v.a;
    divisor  = v.b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'(1));
    end else begin
      exp_q.push_back(pk(v));
      acc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    add(32'h40C00000, 32'h3FC00000, 24'hC00000, 24'hC00000, 1'b0, 10'd129, NORMAL);
`ifdef DIV_PRE_DENORM_EN
    add(32'h00000001, 32'h3F800000, 24'h800000, 24'h800000, 1'b0, 10'h3EA, NORMAL);
`else
    add(32'h00000001, 32'h3F800000, 24'h000000, 24'h000000, 1'b0, 10'h000, ZERO);
`endif
    add(32'h7F800000, 32'h00000000, 24'h0, 24'h0, 1'b0, 10'h0, INF);
    add(32'h80000000, 32'h00000000, 24'h0, 24'h0, 1'b1, 10'h0, NAN);
    add(32'hC0000000, 32'h7F800000, 24'h0, 24'h0, 1'b1, 10'h0, ZERO);
    add(32'h3F800000, 32'h3F800000, 24'h800000, 24'h800000, 1'b0, 10'd127, NORMAL);
    add(32'h7FC00000, 32'h3F800000, 24'h0, 24'h0, 1'b0, 10'h0, NAN);
    add(32'hBF800000, 32'h40000000, 24'h800000, 24'h800000, 1'b1, 10'd126, NORMAL);
    add(32'h7F7FFFFF, 32'h00800000, 24'hFFFFFF, 24'h800000, 1'b0, 10'd380, NORMAL);
    add(32'h00800000, 32'h7F7FFFFF, 24'h800000, 24'hFFFFFF, 1'b0, 10'h382, NORMAL);
    add(32'h7F800000, 32'h7F800000, 24'h0, 24'h0, 1'b0, 10'h0, NAN);
    add(32'h00000000, 32'h00000000, 24'h0, 24'h0, 1'b0, 10'h0, NAN);
    add(32'h3F800000, 32'h7F800000, 24'h0, 24'h0, 1'b0, 10'h0, ZERO);
    add(32'h00000001, 32'h7F800000, 24'h0, 24'h0, 1'b0, 10'h0, ZERO);
    add(32'h7F800000, 32'hBF800000, 24'h0, 24'h0, 1'b1, 10'h0, INF);
`ifdef DIV_PRE_DENORM_EN
    add(32'h00400000, 32'h3F800000, 24'h800000, 24'h800000, 1'b0, 10'd0, NORMAL);
    add(32'h3F800000, 32'h00000001, 24'h800000, 24'h800000, 1'b0, 10'h114, NORMAL);
    add(32'h00000001, 32'h7F7FFFFF, 24'h800000, 24'hFFFFFF, 1'b0, 10'h36B, NORMAL);
    add(32'h7F7FFFFF, 32'h00000001, 24'hFFFFFF, 24'h800000, 1'b0, 10'h193, NORMAL);
`else
    add(32'h00400000, 32'h3F800000, 24'h0, 24'h0, 1'b0, 10'h0, ZERO);
    add(32'h3F800000, 32'h00000001, 24'h0, 24'h0, 1'b0, 10'h0, INF);
    add(32'h00000001, 32'h7F7FFFFF, 24'h0, 24'h0, 1'b0, 10'h0, ZERO);
    add(32'h7F7FFFFF, 32'h00000001, 24'h0, 24'h0, 1'b0, 10'h0, INF);
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_outputs", 64'(out_pk), 64'(0));
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Isolated vectors with latency check
    out_ready = 1'b1;
    lat_chk = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i]);
      idle(3);
    end

    // Back-to-back stream of 8
    out_cyc_q.delete();
    for (int i = 0; i < 8; i++) send(vecs[i]);
    idle(6);
    check("stream_count", 64'(out_cyc_q.size()), 64'(8));
    if (out_cyc_q.size() == 8)
      check("stream_consecutive", 64'(out_cyc_q[7] - out_cyc_q[0]), 64'(7));

    // Downstream stall with three offered pairs
    lat_chk = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        send(vecs[0]);
        send(vecs[5]);
        send(vecs[7]);
        idle(1);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (i >= 2) begin
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_hold", 64'(out_pk), 64'(pk(vecs[0])));
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(6);
    check("stall_drain", 64'(exp_q.size()), 64'(0));

    // Reset pulse with both stages full
    out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[5]);
    rst_n = 1'b0;
    @(negedge clk);
    check("pulse_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("pulse_out_valid", 64'(out_valid), 64'(0));
    check("pulse_outputs", 64'(out_pk), 64'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send(vecs[7]);
    idle(6);
    check("final_drain", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
